// File: rtl/multi_producer.sv
// Four-producer round-robin merge into a small FIFO drained over valid/ready.
// Define MULTI_PRODUCER_TAG_EN to store and present the source index (d_out_src).
module multi_producer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in_0,
  input  logic [WIDTH-1:0] d_in_1,
  input  logic [WIDTH-1:0] d_in_2,
  input  logic [WIDTH-1:0] d_in_3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             d_out_valid,
  input  logic             d_out_ready,
  output logic             rdy
`ifdef MULTI_PRODUCER_TAG_EN
  ,
  output logic [1:0]       d_out_src
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [1:0]       rr_r;
  logic             rdy_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;

  logic             full_s;
  logic [3:0]       gnt_s;
  logic [1:0]       gnt_idx_s;
  logic             found_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] push_data_s;
  logic [AW-1:0]    rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic             head_is_new_s;
  logic [WIDTH-1:0] head_s;

  assign full_s = (count_r == FULL_C);

  // Round-robin search of in_valid starting at rr_r; blocked until ready and while full.
  always_comb begin
    logic [1:0] idx_v;
    idx_v     = 2'd0;
    gnt_s     = 4'b0000;
    gnt_idx_s = rr_r;
    found_s   = 1'b0;
    if (rdy_r && !full_s) begin
      for (int i = 0; i < 4; i++) begin
        idx_v = rr_r + 2'(i);
        if (!found_s && in_valid[idx_v]) begin
          gnt_s[idx_v] = 1'b1;
          gnt_idx_s    = idx_v;
          found_s      = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      gnt_s = 4'b0000;
    end
  end

  // Select the granted producer's word.
  always_comb begin
    case (gnt_idx_s)
      2'd0:    push_data_s = d_in_0;
      2'd1:    push_data_s = d_in_1;
      2'd2:    push_data_s = d_in_2;
      2'd3:    push_data_s = d_in_3;
      default: push_data_s = d_in_0;
    endcase
  end

  assign push_s    = found_s;
  assign pop_s     = dout_valid_r & d_out_ready;
  assign rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

  // Next occupancy from the push/pop pair; simultaneous push and pop leaves it unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // The word being written lands at the head when it is the only valid entry after this edge.
  assign head_is_new_s = push_s && (wr_ptr_r == rd_next_s);
  assign head_s        = head_is_new_s ? push_data_s : mem_r[rd_next_s];

  // FIFO storage, pointers, arbiter pointer and registered head.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      rr_r         <= 2'd0;
      rdy_r        <= 1'b0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      rdy_r <= 1'b1;
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
        rr_r            <= gnt_idx_s + 2'd1;
      end
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      dout_r       <= head_s;
      dout_valid_r <= (count_next_s != '0);
    end
  end

`ifdef MULTI_PRODUCER_TAG_EN
  logic [1:0] src_mem_r [DEPTH];
  logic [1:0] src_r;

  // Source-index shadow of the data FIFO.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) src_mem_r[i] <= 2'd0;
      src_r <= 2'd0;
    end else begin
      if (push_s) begin
        src_mem_r[wr_ptr_r] <= gnt_idx_s;
      end
      src_r <= head_is_new_s ? gnt_idx_s : src_mem_r[rd_next_s];
    end
  end

  assign d_out_src = src_r;
`else
  // No source tags are kept in this build.
`endif

  assign in_ready    = gnt_s;
  assign d_out       = dout_r;
  assign d_out_valid = dout_valid_r;
  assign rdy         = rdy_r;

endmodule
